// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake and data-memory bus of the load/store unit.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [3:0]  mem_we;
   logic [31:0] mem_dout;
   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_dout,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_din, mem_we
   );
   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_dout,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_din, mem_we
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer for a word-addressed memory with byte enables.
// Define LSU_MISALIGN_EN to split word-crossing accesses into two memory cycles instead of rejecting them.
module load_store_unit #(
   parameter int MEM_WORDS = 1024
) (
   input logic               clk,
   input logic               reset,
   load_store_unit_if.slave  bus
);
`ifdef LSU_MISALIGN_EN
   localparam int NB = 8;
`else
   localparam int NB = 4;
`endif
   localparam logic [31:0] LIM = 32'(MEM_WORDS);
   typedef enum logic [2:0] {IDLE, SETUP, ACC1, ACC2, WAIT, ERR} state_t;
   state_t           state_q, state_d;
   logic             store_q, store_d;
   logic [2:0]       f3_q, f3_d;
   logic [1:0]       off_q, off_d;
   logic [29:0]      idx_q, idx_d;
   logic [NB-1:0]    mask_q, mask_d;
   logic [8*NB-1:0]  data_q, data_d;
   logic             cross_q;
   logic [31:0]      lo_q;
   logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [31:0]      rsp_rdata_q, rsp_rdata_d, mem_addr_q, mem_addr_d, mem_din_q, mem_din_d;
   logic [3:0]       mem_we_q, mem_we_d;
   logic [1:0]       off_a;
   logic [29:0]      idx_a;
   logic [2:0]       n_a;
   logic [3:0]       nmask_a;
   logic             legal_a, mis_a, cross_a, oor_a, done;
   logic [31:0]      lo_w, hi_w, sh_w, ld_w;
   assign off_a   = bus.req_addr[1:0];
   assign idx_a   = bus.req_addr[31:2];
   assign n_a     = bus.req_funct3[1:0] == 2'b00 ? 3'd1 : bus.req_funct3[1:0] == 2'b01 ? 3'd2 : 3'd4;
   assign nmask_a = bus.req_funct3[1:0] == 2'b00 ? 4'b0001 : bus.req_funct3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
   assign legal_a = bus.req_funct3[1:0] != 2'b11 &&
                    (bus.req_store ? !bus.req_funct3[2] : bus.req_funct3 != 3'b110);
   assign cross_a = ({1'b0, off_a} + n_a) > 3'd4;
   assign oor_a   = {2'b0, idx_a} >= LIM || (cross_a && {2'b0, idx_a + 30'd1} >= LIM);
`ifdef LSU_MISALIGN_EN
   logic        cross_d;
   logic [31:0] lo_d;
   assign mis_a   = 1'b0;
   assign cross_d = (state_q == IDLE && bus.req_valid) ? cross_a : cross_q;
   assign lo_d    = state_q == ACC2 ? bus.mem_dout : lo_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         cross_q <= 1'b0;
         lo_q    <= 32'd0;
      end else begin
         cross_q <= cross_d;
         lo_q    <= lo_d;
      end
   end
`else
   assign mis_a   = |(off_a & (bus.req_funct3[1:0] == 2'b00 ? 2'b00 :
                               bus.req_funct3[1:0] == 2'b01 ? 2'b01 : 2'b11));
   assign cross_q = 1'b0;
   assign lo_q    = 32'd0;
`endif
   // A crossing load has word0 parked in lo_q while word1 arrives on mem_dout.
   assign lo_w = cross_q ? lo_q : bus.mem_dout;
   assign hi_w = cross_q ? bus.mem_dout : 32'd0;
   assign sh_w = 32'({hi_w, lo_w} >> {off_q, 3'b000});
   assign ld_w = f3_q == 3'b000 ? {{24{sh_w[7]}}, sh_w[7:0]} :
                 f3_q == 3'b001 ? {{16{sh_w[15]}}, sh_w[15:0]} :
                 f3_q == 3'b100 ? {24'd0, sh_w[7:0]} :
                 f3_q == 3'b101 ? {16'd0, sh_w[15:0]} : sh_w;
   assign done = state_q == ERR || state_q == WAIT ||
                 (store_q && (state_q == ACC2 || (state_q == ACC1 && !cross_q)));
   always_comb begin
      state_d = state_q;
      store_d = store_q;
      f3_d    = f3_q;
      off_d   = off_q;
      idx_d   = idx_q;
      mask_d  = mask_q;
      data_d  = data_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            state_d = (!legal_a || mis_a || oor_a) ? ERR : SETUP;
            store_d = bus.req_store;
            f3_d    = bus.req_funct3;
            off_d   = off_a;
            idx_d   = idx_a;
            mask_d  = NB'({4'b0, nmask_a} << off_a);
            data_d  = (8*NB)'({32'b0, bus.req_wdata} << {off_a, 3'b000});
         end
         SETUP:   state_d = ACC1;
         ACC1:    state_d = cross_q ? ACC2 : store_q ? IDLE : WAIT;
         ACC2:    state_d = store_q ? IDLE : WAIT;
         default: state_d = IDLE;
      endcase
      mem_we_d   = 4'b0;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      if (state_d == ACC1) begin
         mem_addr_d = {idx_q, 2'b00};
         mem_din_d  = data_q[31:0];
         mem_we_d   = store_q ? mask_q[3:0] : 4'b0;
      end
`ifdef LSU_MISALIGN_EN
      if (state_d == ACC2) begin
         mem_addr_d = {idx_q + 30'd1, 2'b00};
         mem_din_d  = data_q[63:32];
         mem_we_d   = store_q ? mask_q[7:4] : 4'b0;
      end
`endif
      rsp_valid_d = done;
      rsp_err_d   = done ? state_q == ERR : rsp_err_q;
      rsp_rdata_d = done ? (state_q == WAIT ? ld_w : 32'd0) : rsp_rdata_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         store_q     <= 1'b0;
         f3_q        <= 3'd0;
         off_q       <= 2'd0;
         idx_q       <= 30'd0;
         mask_q      <= '0;
         data_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'd0;
         mem_addr_q  <= 32'd0;
         mem_din_q   <= 32'd0;
         mem_we_q    <= 4'd0;
      end else begin
         state_q     <= state_d;
         store_q     <= store_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         idx_q       <= idx_d;
         mask_q      <= mask_d;
         data_q      <= data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         mem_we_q    <= mem_we_d;
      end
   end
   assign bus.req_ready = state_q == IDLE;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_din   = mem_din_q;
   assign bus.mem_we    = mem_we_q;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's execute stage and the unified word-addressed data memory (32-bit words, byte write enables `mem_we[3:0]`, read data registered one clock after the address is presented). It accepts one load or store request at a time and generates the word address, byte-lane write mask and lane-shifted store data. It extracts and sign/zero-extends load data from the returned word(s). It flags illegal, misaligned or out-of-range accesses instead of issuing them.

## Interface
- `MEM_WORDS`, 1024: number of 32-bit words in the attached memory; valid word index range is 0..MEM_WORDS-1.

- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle; request accepted on an edge where `req_valid & req_ready`.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign code.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: access rejected; valid with `rsp_valid`.
- `mem_addr` out 32: word-aligned byte address to memory (bits [1:0] = 0).
- `mem_din` out 32: lane-shifted store data.
- `mem_we` out 4: byte write enables.
- `mem_dout` in 32: memory read data for the address driven in the previous cycle.

## Operation
- Size n: funct3 000 = 1 byte, 001 = 2 bytes, 010 = 4 bytes.
- Loads also accept 100 (LBU) and 101 (LHU).
- Any other funct3 for loads, and any funct3 other than 000/001/010 for stores, is illegal.
- off = addr[1:0]. The access crosses a word boundary when off+n > 4.
- Word0 = {addr[31:2],2'b00}. Word1 = {addr[31:2]+1,2'b00}, mod 2^32.
- Out-of-range: the word index of word0, or of word1 when the access crosses, is >= MEM_WORDS.
- 8-bit byte mask = ((1<<n)-1) << off. The low nibble drives the word0 `mem_we`, the high nibble drives the word1 `mem_we`.
- Store data = {32'b0,wdata} << (8*off). The low word goes to word0, the high word to word1.
- Load data = {word1,word0} >> (8*off), with word1 = 0 when not crossing.
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW passes through.
- FSM states:
  - IDLE: `req_ready`=1. On accept: illegal, misaligned or out-of-range goes to ERR; otherwise ACC1.
  - ACC1: drive word0 and its mask (stores only). If crossing go to ACC2. Else a store completes and a load goes to WAIT.
  - ACC2: drive word1 and its mask. Latch `mem_dout` (word0) into the low buffer. A store completes; a load goes to WAIT.
  - WAIT: `mem_dout` holds the last-addressed word. Form `rsp_rdata` and complete.
  - ERR: complete with `rsp_err`=1 and no memory access.
  - Complete: the edge loads `rsp_valid`=1, `rsp_err` and `rsp_rdata`, and returns the FSM to IDLE.
- `mem_we`=0 in every state except ACC1/ACC2 of a store. `mem_addr` and `mem_din` hold their last values outside ACC states.
- Reset values: state IDLE, `req_ready` 1, `rsp_valid` 0, `rsp_err` 0, `rsp_rdata` 0, `mem_addr` 0, `mem_din` 0, `mem_we` 0, low buffer 0.
- Reset mid-operation: the next cycle is IDLE with `mem_we`=0. An unissued second store half is dropped, and no `rsp_valid` is generated for the aborted request.

## Timing
- The accept edge is E0; cycle k follows edge Ek.
- Latency from accept to `rsp_valid`:
  - aligned store: cycle 2
  - aligned load: cycle 3
  - crossing store: cycle 3
  - crossing load: cycle 4
  - error: cycle 1
- `rsp_valid` is high for exactly one cycle. `req_ready` is 1 in that same cycle, so a back-to-back request can be accepted on that edge.
- There is no response back-pressure. `req_*` inputs are sampled only at the accept edge.
- A store followed by a load to the same word returns the new data.

## Configuration
- `LSU_MISALIGN_EN` defined:
  - Any access that does not cross a word is issued in one access, e.g. LH at off 1.
  - Crossing accesses are split via ACC2.
- `LSU_MISALIGN_EN` undefined:
  - Any addr not a multiple of n is misaligned and goes to ERR.
  - ACC2 and the low buffer are not built.

## Test plan
- SW addr 0x10, wdata 0xDEADBEEF: cycle 1 shows `mem_addr`=0x10, `mem_we`=1111, `mem_din`=0xDEADBEEF; cycle 2 shows `rsp_valid`=1, `rsp_err`=0.
- SB addr 0x13, wdata 0xA5: cycle 1 shows `mem_we`=1000, `mem_din`=0xA5000000. A following LB at 0x13 returns 0xFFFFFFA5 and LBU returns 0x000000A5, each with `rsp_valid` in cycle 3.
- With word 0x0 = 0x44332211, LH addr 0x1: with the macro, a single access returns 0x00003322; without it, `rsp_err`=1 in cycle 1 and `mem_we` stays 0.
- With the macro, SW addr 0x22, wdata 0xAABBCCDD:
  - cycle 1: addr 0x20, `mem_we` 1100, `mem_din` 0xCCDD0000
  - cycle 2: addr 0x24, `mem_we` 0011, `mem_din` 0x0000AABB
  - `rsp_valid` in cycle 3
  - a following LW at 0x22 returns 0xAABBCCDD in cycle 4
- Load with funct3 011, and SW addr 0x1000 with MEM_WORDS=1024: `rsp_err`=1 and `rsp_rdata`=0 in cycle 1; `mem_we` is never nonzero.
- `reset` asserted during ACC1 of a crossing store: `mem_we`=0 the next cycle, word 0x24 is unchanged, no `rsp_valid`, and `req_ready`=1 after release.
